// File: rtl/banked_mem_4x_if.sv
// Request/response bundle between the cache controller (master) and the
// four-bank interleaved memory (slave).
interface banked_mem_4x_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        data_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, data_valid, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, data_valid, stall, busy, err
  );
endinterface

// File: rtl/banked_mem_4x.sv
// Four-bank word-interleaved memory. Bank = addr[2:1], so a line fill walks
// all four banks on consecutive cycles. Each accepted access occupies its
// bank for BUSY_CYC cycles; reads return exactly two cycles after accept.
module banked_mem_4x #(
  parameter int BANK_AW  = 13,
  parameter int BUSY_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  banked_mem_4x_if.slave   bus
);

  localparam int          DEPTH  = 4 << BANK_AW;
  localparam int          IDX_W  = BANK_AW + 2;
  localparam logic [3:0]  RELOAD = 4'(BUSY_CYC - 1);

  logic [1:0]         req_bank;
  logic [BANK_AW-1:0] req_row;
  logic               any_req;
  logic               illegal;
  logic               accept;
  logic [3:0]         busy;

  logic [3:0]         cnt_q [4];
  logic [3:0]         cnt_d [4];

  logic               s1_vld_q;
  logic               s1_wr_q;
  logic [IDX_W-1:0]   s1_idx_q;
  logic [15:0]        s1_data_q;

  logic [15:0]        data_out_q;
  logic               data_valid_q;
  logic               err_q;

  // NOTE: the array has no reset; its contents survive rst and start at zero
  // only through this declaration initialiser.
  logic [15:0]        mem_q [DEPTH] = '{default: 16'h0000};

  assign req_bank = bus.addr[2:1];
  assign req_row  = bus.addr[BANK_AW+2:3];
  assign any_req  = bus.rd | bus.wr;
  assign illegal  = (bus.rd & bus.wr) | (any_req & bus.addr[0]);

  // A bank is busy while its occupancy counter is nonzero.
  always_comb begin
    for (int i = 0; i < 4; i++) busy[i] = (cnt_q[i] != 4'd0);
  end

  assign accept = any_req & ~illegal & ~busy[req_bank];

  // Occupancy counters: reload on accept, otherwise count down to zero.
  always_comb begin
    // NOTE: every bank gets its hold value first so no path leaves cnt_d
    // unassigned, which would otherwise infer a latch.
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept && req_bank == 2'(i))
        cnt_d[i] = RELOAD;
      else if (cnt_q[i] != 4'd0)
        cnt_d[i] = cnt_q[i] - 4'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Stage 1: capture the accepted request; only the valid bit is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= accept;
    end
    if (accept) begin
      s1_wr_q   <= bus.wr;
      s1_idx_q  <= {req_row, req_bank};
      s1_data_q <= bus.data_in;
    end
  end

  // Array write at the end of the cycle after accept; reset drops it.
  always_ff @(posedge clk) begin
    if (!rst && s1_vld_q && s1_wr_q) mem_q[s1_idx_q] <= s1_data_q;
  end

  // Read data register and illegal-request pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_valid_q <= 1'b0;
      data_out_q   <= 16'h0000;
      err_q        <= 1'b0;
    end else begin
      data_valid_q <= s1_vld_q & ~s1_wr_q;
      data_out_q   <= (s1_vld_q && !s1_wr_q) ? mem_q[s1_idx_q] : 16'h0000;
      err_q        <= illegal;
    end
  end

  assign bus.stall      = any_req & busy[req_bank];
  assign bus.busy       = busy;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_banked_mem_4x.sv
// Directed plus randomized bench for banked_mem_4x. The reference model keeps
// a word-addressed memory, a "bank free at cycle" timestamp per bank and a
// queue of pending read returns, and is compared against the DUT every cycle.
module tb_banked_mem_4x;

  localparam int BUSY_CYC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  banked_mem_4x_if bus ();

  banked_mem_4x #(.BANK_AW(13), .BUSY_CYC(BUSY_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          ret_cyc;
    logic [15:0] data;
  } rd_ret_t;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          free_at [4];
  rd_ret_t     rq [$];
  logic [15:0] mdl_mem [int];
  logic        pend_vld = 1'b0;
  int          pend_word;
  logic [15:0] pend_data;
  logic        err_exp = 1'b0;
  logic        last_stall = 1'b0;
  logic        dut_stall;
  logic [15:0] last_rd_data;

  function automatic logic [15:0] mdl_read(input int word);
    return mdl_mem.exists(word) ? mdl_mem[word] : 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic cycle(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic rs, input logic chk);
    logic [3:0]  exp_busy;
    logic [1:0]  b;
    logic        exp_stall, exp_valid, ill;
    logic [15:0] exp_dout;
    bus.rd = r; bus.wr = w; bus.addr = a; bus.data_in = d; rst = rs;
    @(negedge clk);
    b = a[2:1];
    for (int i = 0; i < 4; i++) exp_busy[i] = (cyc < free_at[i]);
    exp_stall = (r | w) & exp_busy[b];
    exp_valid = 1'b0;
    exp_dout  = 16'h0000;
    if (rq.size() > 0 && rq[0].ret_cyc == cyc) begin
      exp_valid = 1'b1;
      exp_dout  = rq[0].data;
      void'(rq.pop_front());
    end
    dut_stall = bus.stall;
    if (bus.data_valid === 1'b1) last_rd_data = bus.data_out;
    if (chk) begin
      check("busy",       32'(bus.busy),       32'(exp_busy));
      check("stall",      32'(bus.stall),      32'(exp_stall));
      check("data_valid", 32'(bus.data_valid), 32'(exp_valid));
      check("data_out",   32'(bus.data_out),   32'(exp_dout));
      check("err",        32'(bus.err),        32'(err_exp));
    end
    last_stall = exp_stall;
    ill = (r & w) | ((r | w) & a[0]);
    if (rs) begin
      for (int i = 0; i < 4; i++) free_at[i] = 0;
      rq.delete();
      pend_vld = 1'b0;
      err_exp  = 1'b0;
    end else begin
      if (pend_vld) mdl_mem[pend_word] = pend_data;
      pend_vld = 1'b0;
      err_exp  = ill;
      if (!ill && (r | w) && !exp_busy[b]) begin
        free_at[b] = cyc + BUSY_CYC;
        if (w) begin
          pend_vld  = 1'b1;
          pend_word = int'(a[15:1]);
          pend_data = d;
        end else begin
          rq.push_back('{ret_cyc: cyc + 2, data: mdl_read(int'(a[15:1]))});
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    cycle(r, w, a, d, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
  endtask

  initial begin
    int          n_stalled;
    logic        r, w;
    logic [15:0] a, d;
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 16'h0000; bus.data_in = 16'h0000;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset; the second reset cycle checks the reset state.
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    idle(2);

    // 1: write then read back after the bank frees.
    req(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    idle(3);
    req(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(3);
    check("t1_readback", 32'(last_rd_data), 32'h0000BEEF);

    // 2: back-to-back reads over all four banks.
    req(1'b1, 1'b0, 16'h0000, 16'h0000);
    req(1'b1, 1'b0, 16'h0002, 16'h0000);
    req(1'b1, 1'b0, 16'h0004, 16'h0000);
    req(1'b1, 1'b0, 16'h0006, 16'h0000);
    idle(5);

    // 3: same-bank read held while stalled.
    req(1'b1, 1'b0, 16'h0008, 16'h0000);
    n_stalled = 0;
    for (int k = 0; k < 10; k++) begin
      req(1'b1, 1'b0, 16'h0000, 16'h0000);
      if (dut_stall === 1'b1) n_stalled++;
      if (!last_stall) break;
    end
    check("t3_stall_cycles", 32'(n_stalled), 32'd3);
    idle(4);

    // 4: illegal requests.
    req(1'b1, 1'b1, 16'h0002, 16'h5555);
    req(1'b1, 1'b0, 16'h0003, 16'h0000);
    idle(3);

    // 5: write dropped by reset in the following cycle.
    req(1'b0, 1'b1, 16'h0020, 16'h1234);
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    idle(4);
    last_rd_data = 16'hFFFF;
    req(1'b1, 1'b0, 16'h0020, 16'h0000);
    idle(3);
    check("t5_dropped_write", 32'(last_rd_data), 32'h00000000);

    // 6: line fill interleaved with writeback to another tag.
    for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 16'(16'h0040 + 2 * i), 16'h0000);
    for (int i = 0; i < 4; i++) req(1'b0, 1'b1, 16'(16'h0080 + 2 * i), 16'(16'hA000 + i));
    idle(5);
    for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 16'(16'h0080 + 2 * i), 16'h0000);
    idle(5);

    // Randomized traffic over a small address window; stalled requests held.
    r = 1'b0; w = 1'b0; a = 16'h0000; d = 16'h0000;
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) begin
        int kind;
        kind = int'($urandom_range(0, 15));
        a = 16'($urandom_range(0, 15) << 1);
        d = 16'($urandom);
        r = 1'b0; w = 1'b0;
        if (kind == 4) begin r = 1'b1; w = 1'b1; end
        else if (kind == 5) begin r = 1'b1; a[0] = 1'b1; end
        else if (kind >= 6 && kind <= 10) r = 1'b1;
        else if (kind >= 11) w = 1'b1;
      end
      cycle(r, w, a, d, ($urandom_range(0, 99) == 0), 1'b1);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
